simpletron_io_port: RTL and testbench

Word-level I/O responder for the Simpletron core: services the CPU's READ (opcode 10) and WRITE (opcode 11) instructions over a level-request / pulse-acknowledge handshake. Buffers host-supplied input words and CPU-produced output words in two small first-word-fall-through FIFOs. Sits beside the memory unit inside `Toplevel`. The host side is a valid/ready stream pair that a bench or console front-end drives and drains.

---
 rtl/simpletron_io_port.sv | 230 +++++++++++++++++++++++
 tb/tb_simpletron_io_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simpletron_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : simpletron_io_port
//  Description : Word-level I/O responder for the Simpletron CPU. Services
//                READ/WRITE instructions over a level-request / pulse-ack
//                handshake. Host input and CPU output words are buffered in
//                two first-word-fall-through FIFOs.
//                Optional build macro SIMPLETRON_IO_CLAMP_EN: clamp host
//                words to +/-9999 and flag out-of-range words in range_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module simpletron_io_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_req,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rd_ack,
    input  logic              cpu_wr_req,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ack,
    input  logic              host_in_valid,
    input  logic [DATA_W-1:0] host_in_data,
    output logic              host_in_ready,
    output logic              host_out_valid,
    output logic [DATA_W-1:0] host_out_data,
    input  logic              host_out_ready,
    output logic [ADDR_W:0]   in_level,
    output logic [ADDR_W:0]   out_level,
    output logic              range_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_WAIT = 2'd1;
    localparam logic [1:0] c_WR_WAIT = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   c_LVL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_LVL_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_in_pop;
    logic              w_out_push;
    logic              w_rd_done;
    logic              w_wr_done;

    logic [DATA_W-1:0] r_in_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_in_wptr;
    logic [ADDR_W-1:0] r_in_rptr;
    logic [ADDR_W:0]   r_in_level;
    logic              w_in_push;
    logic              w_in_empty;
    logic [DATA_W-1:0] w_in_word;

    logic [DATA_W-1:0] r_out_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_out_wptr;
    logic [ADDR_W-1:0] r_out_rptr;
    logic [ADDR_W:0]   r_out_level;
    logic              w_out_pop;
    logic              w_out_full;

    logic              r_rd_ack;
    logic              r_wr_ack;
    logic [DATA_W-1:0] r_rd_data;

    assign w_in_empty     = (r_in_level == '0);
    assign host_in_ready  = (r_in_level != c_LVL_MAX);
    assign w_in_push      = host_in_valid & host_in_ready;

    assign w_out_full     = (r_out_level == c_LVL_MAX);
    assign host_out_valid = (r_out_level != '0);
    assign w_out_pop      = host_out_valid & host_out_ready;
    assign host_out_data  = r_out_mem[r_out_rptr];

    assign in_level       = r_in_level;
    assign out_level      = r_out_level;
    assign cpu_rd_ack     = r_rd_ack;
    assign cpu_wr_ack     = r_wr_ack;
    assign cpu_rd_data    = r_rd_data;

`ifdef SIMPLETRON_IO_CLAMP_EN
    localparam logic signed [DATA_W-1:0] c_POS_LIM = DATA_W'(9999);
    localparam logic signed [DATA_W-1:0] c_NEG_LIM = DATA_W'(-9999);

    logic w_too_high;
    logic w_too_low;
    logic r_range_err;

    assign w_too_high = ($signed(host_in_data) > c_POS_LIM);
    assign w_too_low  = ($signed(host_in_data) < c_NEG_LIM);
    assign w_in_word  = w_too_high ? c_POS_LIM :
                        w_too_low  ? c_NEG_LIM : host_in_data;
    assign range_err  = r_range_err;

    // Sticky flag: any accepted host word outside the Simpletron word range
    always_ff @(posedge clk) begin
        if (reset) begin
            r_range_err <= 1'b0;
        end else if (w_in_push && (w_too_high || w_too_low)) begin
            r_range_err <= 1'b1;
        end
    end
`else
    assign w_in_word = host_in_data;
    assign range_err = 1'b0;
`endif

    // Handshake FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and FIFO strobes; requests are only looked at in IDLE,
    // with a read winning over a simultaneous write
    always_comb begin
        w_state_nxt = r_state;
        w_in_pop    = 1'b0;
        w_out_push  = 1'b0;
        w_rd_done   = 1'b0;
        w_wr_done   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (cpu_rd_req) begin
                    if (!w_in_empty) begin
                        w_in_pop    = 1'b1;
                        w_rd_done   = 1'b1;
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_RD_WAIT;
                    end
                end else if (cpu_wr_req) begin
                    if (!w_out_full) begin
                        w_out_push  = 1'b1;
                        w_wr_done   = 1'b1;
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_WR_WAIT;
                    end
                end
            end
            c_RD_WAIT: begin
                if (!w_in_empty) begin
                    w_in_pop    = 1'b1;
                    w_rd_done   = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_WR_WAIT: begin
                if (!w_out_full) begin
                    w_out_push  = 1'b1;
                    w_wr_done   = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Registered ack pulses and read data, captured as the FSM enters DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ack  <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= w_rd_done;
            r_wr_ack <= w_wr_done;
            if (w_in_pop) begin
                r_rd_data <= r_in_mem[r_in_rptr];
            end
        end
    end

    // Input FIFO: host pushes, FSM pops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_level <= '0;
        end else begin
            if (w_in_push) begin
                r_in_mem[r_in_wptr] <= w_in_word;
                r_in_wptr           <= r_in_wptr + c_PTR_ONE;
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + c_PTR_ONE;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_level <= r_in_level + c_LVL_ONE;
                2'b01:   r_in_level <= r_in_level - c_LVL_ONE;
                default: r_in_level <= r_in_level;
            endcase
        end
    end

    // Output FIFO: FSM pushes, host pops from the fall-through head
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_wptr  <= '0;
            r_out_rptr  <= '0;
            r_out_level <= '0;
        end else begin
            if (w_out_push) begin
                r_out_mem[r_out_wptr] <= cpu_wr_data;
                r_out_wptr            <= r_out_wptr + c_PTR_ONE;
            end
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + c_PTR_ONE;
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_level <= r_out_level + c_LVL_ONE;
                2'b01:   r_out_level <= r_out_level - c_LVL_ONE;
                default: r_out_level <= r_out_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simpletron_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simpletron_io_port
//  Description : Directed self-checking bench for simpletron_io_port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simpletron_io_port;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_rd_req;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_rd_ack;
    logic              cpu_wr_req;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ack;
    logic              host_in_valid;
    logic [DATA_W-1:0] host_in_data;
    logic              host_in_ready;
    logic              host_out_valid;
    logic [DATA_W-1:0] host_out_data;
    logic              host_out_ready;
    logic [ADDR_W:0]   in_level;
    logic [ADDR_W:0]   out_level;
    logic              range_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] got_q [$];
    int                acks;
    logic              saw_ack;
    logic [DATA_W-1:0] exp_hi;
    logic [DATA_W-1:0] exp_lo;
    logic              exp_err;

    simpletron_io_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_rd_req     (cpu_rd_req),
        .cpu_rd_data    (cpu_rd_data),
        .cpu_rd_ack     (cpu_rd_ack),
        .cpu_wr_req     (cpu_wr_req),
        .cpu_wr_data    (cpu_wr_data),
        .cpu_wr_ack     (cpu_wr_ack),
        .host_in_valid  (host_in_valid),
        .host_in_data   (host_in_data),
        .host_in_ready  (host_in_ready),
        .host_out_valid (host_out_valid),
        .host_out_data  (host_out_data),
        .host_out_ready (host_out_ready),
        .in_level       (in_level),
        .out_level      (out_level),
        .range_err      (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [DATA_W-1:0] d);
        host_in_valid = 1'b1;
        host_in_data  = d;
        tick();
        host_in_valid = 1'b0;
    endtask

    // Read with data already buffered: ack must follow one edge after the request
    task automatic cpu_read(input string tag, input logic [DATA_W-1:0] exp);
        int n;
        n = 0;
        cpu_rd_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!cpu_rd_ack && n < 20);
        cpu_rd_req = 1'b0;
        check({tag, "_ack"}, 32'(cpu_rd_ack), 32'd1);
        check({tag, "_data"}, 32'(cpu_rd_data), 32'(exp));
        check({tag, "_lat"}, n, 32'd1);
        tick();
    endtask

    task automatic cpu_write(input string tag, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        cpu_wr_req  = 1'b1;
        cpu_wr_data = d;
        do begin
            tick();
            n++;
        end while (!cpu_wr_ack && n < 20);
        cpu_wr_req = 1'b0;
        check({tag, "_ack"}, 32'(cpu_wr_ack), 32'd1);
        check({tag, "_lat"}, n, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        cpu_rd_req     = 1'b0;
        cpu_wr_req     = 1'b0;
        cpu_wr_data    = '0;
        host_in_valid  = 1'b0;
        host_in_data   = '0;
        host_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values
        check("rst_rd_ack",    32'(cpu_rd_ack),     32'd0);
        check("rst_wr_ack",    32'(cpu_wr_ack),     32'd0);
        check("rst_out_valid", 32'(host_out_valid), 32'd0);
        check("rst_range_err", 32'(range_err),      32'd0);
        check("rst_rd_data",   32'(cpu_rd_data),    32'd0);
        check("rst_in_ready",  32'(host_in_ready),  32'd1);
        check("rst_in_level",  32'(in_level),       32'd0);
        check("rst_out_level", 32'(out_level),      32'd0);

        // Buffered reads, filling the input FIFO to full
        host_push(16'd7);
        host_push(16'(-3));
        host_push(16'd120);
        host_push(16'd55);
        check("in_full_level", 32'(in_level),      32'd4);
        check("in_full_ready", 32'(host_in_ready), 32'd0);
        cpu_read("rd7",   16'd7);
        cpu_read("rdm3",  16'hFFFD);
        cpu_read("rd120", 16'd120);
        cpu_read("rd55",  16'd55);
        check("in_empty_level", 32'(in_level),      32'd0);
        check("in_empty_ready", 32'(host_in_ready), 32'd1);

        // Read from empty FIFO: waits, then acks two cycles after the host push
        cpu_rd_req = 1'b1;
        acks = 0;
        repeat (5) begin
            tick();
            if (cpu_rd_ack) acks++;
        end
        check("rdwait_no_ack", acks, 32'd0);
        host_push(16'd42);
        check("rdwait_ack_after_push1", 32'(cpu_rd_ack), 32'd0);
        tick();
        check("rdwait_ack_after_push2", 32'(cpu_rd_ack), 32'd1);
        check("rdwait_data",            32'(cpu_rd_data), 32'd42);
        cpu_rd_req = 1'b0;
        tick();
        check("rdwait_ack_pulse", 32'(cpu_rd_ack), 32'd0);

        // Writes into a blocked output FIFO
        cpu_write("wr1", 16'd1);
        cpu_write("wr2", 16'd2);
        cpu_write("wr3", 16'd3);
        cpu_write("wr4", 16'd4);
        check("out_full_level", 32'(out_level), 32'd4);
        check("out_head",       32'(host_out_data), 32'd1);
        cpu_wr_data = 16'd5;
        cpu_wr_req  = 1'b1;
        acks = 0;
        repeat (3) begin
            tick();
            if (cpu_wr_ack) acks++;
        end
        check("wr5_wait_no_ack", acks, 32'd0);
        check("wr5_wait_level",  32'(out_level), 32'd4);
        host_out_ready = 1'b1;
        saw_ack = 1'b0;
        got_q.delete();
        for (int i = 0; i < 20 && got_q.size() < 5; i++) begin
            if (host_out_valid) got_q.push_back(host_out_data);
            tick();
            if (cpu_wr_ack) begin
                saw_ack    = 1'b1;
                cpu_wr_req = 1'b0;
            end
        end
        host_out_ready = 1'b0;
        cpu_wr_req     = 1'b0;
        check("wr5_ack",        32'(saw_ack),     32'd1);
        check("drain_count",    got_q.size(),     32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check($sformatf("drain_%0d", i), 32'(got_q[i]), i + 1);
        end
        check("drain_level",    32'(out_level),      32'd0);
        check("drain_valid",    32'(host_out_valid), 32'd0);
        tick();

        // Simultaneous read and write: read first
        host_push(16'd77);
        cpu_wr_data = 16'd9;
        cpu_rd_req  = 1'b1;
        cpu_wr_req  = 1'b1;
        tick();
        check("both_rd_ack",  32'(cpu_rd_ack),  32'd1);
        check("both_wr_ack0", 32'(cpu_wr_ack),  32'd0);
        check("both_rd_data", 32'(cpu_rd_data), 32'd77);
        cpu_rd_req = 1'b0;
        tick();
        check("both_wr_ack1", 32'(cpu_wr_ack), 32'd0);
        tick();
        check("both_wr_ack2", 32'(cpu_wr_ack), 32'd1);
        cpu_wr_req = 1'b0;
        check("both_out_data", 32'(host_out_data), 32'd9);
        host_out_ready = 1'b1;
        tick();
        host_out_ready = 1'b0;
        check("both_out_level", 32'(out_level), 32'd0);

        // Range handling
`ifdef SIMPLETRON_IO_CLAMP_EN
        exp_hi  = 16'd9999;
        exp_lo  = 16'(-9999);
        exp_err = 1'b1;
`else
        exp_hi  = 16'd12000;
        exp_lo  = 16'(-10001);
        exp_err = 1'b0;
`endif
        check("range_err_before", 32'(range_err), 32'd0);
        host_push(16'd12000);
        host_push(16'(-10001));
        cpu_read("rng_hi", exp_hi);
        cpu_read("rng_lo", exp_lo);
        check("range_err_set", 32'(range_err), 32'(exp_err));
        host_push(16'd5);
        cpu_read("rng_ok", 16'd5);
        check("range_err_sticky", 32'(range_err), 32'(exp_err));

        // Reset while stuck in RD_WAIT with output words buffered
        cpu_write("pre_rst_a", 16'd11);
        cpu_write("pre_rst_b", 16'd12);
        check("pre_rst_out_level", 32'(out_level), 32'd2);
        cpu_rd_req = 1'b1;
        tick();
        tick();
        check("pre_rst_no_ack", 32'(cpu_rd_ack), 32'd0);
        reset      = 1'b1;
        cpu_rd_req = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_in_level",  32'(in_level),       32'd0);
        check("mid_rst_out_level", 32'(out_level),      32'd0);
        check("mid_rst_rd_ack",    32'(cpu_rd_ack),     32'd0);
        check("mid_rst_out_valid", 32'(host_out_valid), 32'd0);
        check("mid_rst_rd_data",   32'(cpu_rd_data),    32'd0);
        check("mid_rst_range_err", 32'(range_err),      32'd0);
        tick();
        check("post_rst_rd_ack",   32'(cpu_rd_ack),     32'd0);
        host_push(16'd3);
        cpu_read("post_rst", 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
